// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative RV32M multiply/divide unit.
// The requester drives operands and accepts results; the unit answers.
interface muldiv_unit_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out;
    logic            busy;

    modport master (
        output in_valid, funct3, in1, in2, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, funct3, in1, in2, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies by shift-add and divides by restoring division, one bit per
// cycle on operand magnitudes. Signs are applied in a single fix-up cycle.
// Divide-by-zero and signed overflow skip the iteration phase entirely.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic                neg_q, neg_d;
    logic                special_q, special_d;
    logic [XLEN-1:0]     out_q, out_d;

    // Decode of the incoming request, used only on the accept edge.
    logic                is_div;
    logic                sgn1, sgn2;
    logic                neg1, neg2;
    logic [XLEN-1:0]     mag1, mag2;
    logic                div_zero, div_ovf;
    logic                req_neg;
    logic [XLEN-1:0]     special_val;

    // Per-iteration datapath values.
    logic [XLEN:0]       add_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       rem_shift;
    logic [XLEN:0]       diff;
    logic [2*XLEN-1:0]   div_next;

    // Fix-up stage values.
    logic [2*XLEN-1:0]   mul_full;
    logic [XLEN-1:0]     quot_s, rem_s;
    logic [XLEN-1:0]     fix_result;

    assign is_div  = bus.funct3[2];
    // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
    // Signed division ops are the ones with funct3[0] clear.
    assign sgn1    = is_div ? ~bus.funct3[0]
                            : (bus.funct3[1:0] == 2'b01) || (bus.funct3[1:0] == 2'b10);
    assign sgn2    = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
    assign neg1    = sgn1 & bus.in1[XLEN-1];
    assign neg2    = sgn2 & bus.in2[XLEN-1];
    assign mag1    = neg1 ? -bus.in1 : bus.in1;
    assign mag2    = neg2 ? -bus.in2 : bus.in2;

    assign div_zero = is_div && (bus.in2 == '0);
    assign div_ovf  = is_div && ~bus.funct3[0]
                      && (bus.in1 == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.in2 == '1);

    // Remainder follows the dividend; everything else follows the sign product.
    assign req_neg     = (is_div && bus.funct3[1]) ? neg1 : (neg1 ^ neg2);
    assign special_val = div_zero ? (bus.funct3[1] ? bus.in1 : '1)
                                  : (bus.funct3[1] ? '0 : bus.in1);

    // Shift-add step: accumulate into the high half, shift the multiplier out of the low half.
    assign add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {add_sum, acc_q[XLEN-1:1]};

    // Restoring step: high half is the partial remainder, low half shifts dividend out and quotient in.
    assign rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign diff      = rem_shift - {1'b0, opb_q};
    assign div_next  = diff[XLEN] ? {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {diff[XLEN-1:0],      acc_q[XLEN-2:0], 1'b1};

    assign mul_full = neg_q ? -acc_q : acc_q;
    assign quot_s   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_s    = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    // Select the signed result for the operation held since accept.
    always_comb begin
        fix_result = rem_s;
        if (special_q) begin
            fix_result = acc_q[XLEN-1:0];
        end else begin
            case (op_q)
                3'b000:                 fix_result = mul_full[XLEN-1:0];
                3'b001, 3'b010, 3'b011: fix_result = mul_full[2*XLEN-1:XLEN];
                3'b100, 3'b101:         fix_result = quot_s;
                default:                fix_result = rem_s;
            endcase
        end
    end

    // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        special_d = special_q;
        out_d     = out_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d  = bus.funct3;
                    cnt_d = '0;
                    if (div_zero || div_ovf) begin
                        special_d = 1'b1;
                        neg_d     = 1'b0;
                        opb_d     = '0;
                        acc_d     = {{XLEN{1'b0}}, special_val};
                        state_d   = FIX;
                    end else begin
                        special_d = 1'b0;
                        neg_d     = req_neg;
                        opb_d     = is_div ? mag2 : mag1;
                        acc_d     = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIX: begin
                out_d   = fix_result;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            out_q     <= out_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out       = out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors with
// hand-computed results and latencies, backpressure and reset abort.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    typedef struct {
        string       name;
        logic [31:0] exp_out;
        int          exp_lat;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycle index used to measure accept-to-result latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Wait for the unit to be ready, present one request, and record the expectation.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_out,
                                 input int exp_lat, input string name, input bit track);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL %s_ready_timeout actual=0 required=1", name);
            return;
        end
        bus.funct3   = f;
        bus.in1      = a;
        bus.in2      = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (track) begin
            e.name    = name;
            e.exp_out = exp_out;
            e.exp_lat = exp_lat;
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
        // Scramble operands after accept; the unit must have captured them.
        bus.in_valid = 1'b0;
        bus.funct3   = 3'($urandom);
        bus.in1      = 32'($urandom);
        bus.in2      = 32'($urandom);
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL drain_timeout actual=%0d required=0", sb_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compare each newly presented result against the oldest expectation.
    initial begin : monitor
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (bus.out_valid && !seen) begin
                seen = 1'b1;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("[TB] FAIL unexpected_output actual=0x%0h required=none", bus.out);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput({e.name, "_out"}, 64'(bus.out), 64'(e.exp_out));
                    checkOutput({e.name, "_lat"}, 64'(cyc - e.acc_cyc + 1), 64'(e.exp_lat));
                end
            end else if (!bus.out_valid) begin
                seen = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin : stimulus
        int t;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.funct3    = 3'b000;
        bus.in1       = '0;
        bus.in2       = '0;

        // Reset state.
        @(negedge clk);
        checkOutput("rst_in_ready",  64'(bus.in_ready),  64'd0);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_busy",      64'(bus.busy),      64'd0);
        checkOutput("rst_out",       64'(bus.out),       64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Multiply family.
        applyStimulus(3'b000, 32'd112233, 32'd332211, 32'd2925298795, 34, "mul", 1'b1);
        @(negedge clk);
        checkOutput("calc_busy",     64'(bus.busy),     64'd1);
        checkOutput("calc_in_ready", 64'(bus.in_ready), 64'd0);
        applyStimulus(3'b011, 32'd112233, 32'd332211, 32'd8, 34, "mulhu", 1'b1);
        applyStimulus(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 34, "mulh_m1", 1'b1);
        applyStimulus(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu_m1", 1'b1);
        applyStimulus(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 34, "mul_m1", 1'b1);
        applyStimulus(3'b001, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 34, "mulh_neg", 1'b1);

        // Divide family.
        applyStimulus(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "div_m7_2", 1'b1);
        applyStimulus(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "rem_m7_2", 1'b1);
        applyStimulus(3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34, "div_7_m2", 1'b1);
        applyStimulus(3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 34, "rem_7_m2", 1'b1);
        applyStimulus(3'b101, 32'd332211, 32'd112233, 32'd2, 34, "divu", 1'b1);
        applyStimulus(3'b111, 32'd332211, 32'd112233, 32'd107745, 34, "remu", 1'b1);

        // Divide by zero and signed overflow bypass the iterations.
        applyStimulus(3'b101, 32'd332211, 32'd0, 32'hFFFFFFFF, 2, "divu_z", 1'b1);
        applyStimulus(3'b111, 32'd332211, 32'd0, 32'd332211, 2, "remu_z", 1'b1);
        applyStimulus(3'b100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 2, "div_z", 1'b1);
        applyStimulus(3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 2, "rem_z", 1'b1);
        applyStimulus(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, "div_ovf", 1'b1);
        applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 2, "rem_ovf", 1'b1);
        applyStimulus(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h0, 34, "divu_big", 1'b1);
        applyStimulus(3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, "remu_big", 1'b1);
        waitDrain();

        // Backpressure: result held, requests ignored while DONE.
        bus.out_ready = 1'b0;
        applyStimulus(3'b000, 32'd112233, 32'd332211, 32'd2925298795, 34, "mul_bp", 1'b1);
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        checkOutput("bp_valid_seen", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_out",   64'(bus.out),       64'd2925298795);
            checkOutput("bp_in_ready",   64'(bus.in_ready),  64'd0);
            checkOutput("bp_out_valid",  64'(bus.out_valid), 64'd1);
            bus.funct3   = 3'b000;
            bus.in1      = 32'd3;
            bus.in2      = 32'd5;
            bus.in_valid = 1'b1;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_in_ready",  64'(bus.in_ready),  64'd1);
        checkOutput("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("bp_no_queued_req", 64'(bus.busy), 64'd0);

        // Reset in the middle of CALC aborts the operation.
        applyStimulus(3'b000, 32'h1234, 32'h5678, 32'h0, 0, "abort", 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("abort_out",       64'(bus.out),       64'd0);
        checkOutput("abort_busy",      64'(bus.busy),      64'd0);
        checkOutput("abort_in_ready",  64'(bus.in_ready),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("abort_rel_in_ready", 64'(bus.in_ready), 64'd1);
        applyStimulus(3'b000, 32'd3, 32'd5, 32'd15, 34, "mul_after_rst", 1'b1);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits; SHALL be any even value >= 8.
REQ-002 Parameter CNT_W, default 6, iteration counter width; SHALL satisfy 2^CNT_W > XLEN.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request operands valid.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 in1  input  XLEN  rs1 operand (multiplicand/dividend).
REQ-009 in2  input  XLEN  rs2 operand (multiplier/divisor).
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out  output  XLEN  registered result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, CALC, FIX, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-015 Accept occurs on an edge with in_valid && in_ready; funct3, in1, in2 SHALL be captured at that edge and later input changes ignored.
REQ-016 in_valid outside IDLE SHALL be ignored; no queuing.
REQ-017 Normal ops: IDLE->CALC on accept; CALC SHALL run exactly XLEN iterations (counter 0..XLEN-1); CALC->FIX after the last iteration; FIX->DONE after one cycle; out_valid first seen XLEN+2 edges after the accept edge.
REQ-018 Multiply SHALL be iterative shift-add on operand magnitudes producing a 2*XLEN-bit product; signedness: MULH both signed, MULHSU in1 signed/in2 unsigned, MULHU/MUL unsigned product treatment per RISC-V spec.
REQ-019 MUL SHALL return product[XLEN-1:0]; MULH/MULHSU/MULHU SHALL return product[2*XLEN-1:XLEN] after sign fix in FIX.
REQ-020 Divide SHALL be restoring, one quotient bit per CALC cycle on magnitudes; FIX applies signs: quotient negative iff operand signs differ, remainder takes dividend sign (DIV/REM only).
REQ-021 Divide by zero (in2 == 0, any div/rem op): SHALL bypass CALC (IDLE->FIX->DONE); DIV/DIVU out = all ones, REM/REMU out = in1; out_valid seen 2 edges after accept.
REQ-022 Signed overflow (DIV/REM, in1 = 1 followed by XLEN-1 zeros, in2 = all ones): SHALL bypass CALC; DIV out = in1, REM out = 0; 2-edge latency.
REQ-023 DONE: out SHALL hold stable while out_ready low; on edge with out_ready high go to IDLE; in_ready high the following cycle (no same-edge re-accept).
REQ-024 out SHALL be written only on the FIX->DONE edge.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counter 0, out 0, all internal operand/accumulator registers 0, regardless of clk.
REQ-026 During reset: in_ready 0, out_valid 0, busy 0; in_ready SHALL be 1 on the first cycle after rst_n rises.
REQ-027 Reset asserted mid-CALC/FIX/DONE SHALL abort the operation with no result produced.

Verification (XLEN=32)
REQ-028 MUL 112233 x 332211 -> out 2925298795, out_valid 34 edges after accept; MULHU same operands -> 8; MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-029 DIV -7 / 2 -> 0xFFFFFFFD (-3); REM -7 % 2 -> 0xFFFFFFFF (-1); DIVU 332211 / 112233 -> 2; REMU -> 107745.
REQ-030 DIVU 332211 / 0 -> 0xFFFFFFFF and REMU -> 332211, each with out_valid 2 edges after accept.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; 2-edge latency.
REQ-032 Backpressure: hold out_ready low 5 cycles after out_valid -> out constant, in_ready 0, in_valid pulses ignored; raise out_ready -> IDLE next edge, in_ready 1.
REQ-033 Reset pulse 10 cycles into CALC -> out_valid 0, out 0, busy 0 immediately; after release, a following MUL 3 x 5 -> 15 with normal latency.
